// File: rtl/st_width_adapter_32_to_8.sv
// Streaming width adapter: one 32-bit word in, up to four 8-bit symbols out, MSB symbol first.
// Optional error pass-through is enabled with `define ST_WIDTH_ADAPTER_ERROR_EN.
module st_width_adapter_32_to_8 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_startofpacket,
    input  logic        in_endofpacket,
    input  logic [1:0]  in_empty,
`ifdef ST_WIDTH_ADAPTER_ERROR_EN
    input  logic        in_error,
    output logic        out_error,
`endif
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_startofpacket,
    output logic        out_endofpacket,
    output logic        state_address,
    output logic [1:0]  state_writedata,
    output logic        state_write,
    input  logic        state_waitrequest
);

    logic [31:0] data_r;
    logic        sop_r;
    logic        eop_r;
    logic [1:0]  last_r;
    logic        valid_r;
    logic [1:0]  byte_idx;

    logic        stall;
    logic        at_last;
    logic        accept;
    logic        emit;
    logic        valid_nxt;
    logic [1:0]  byte_idx_nxt;

    assign stall     = state_waitrequest;
    assign at_last   = (byte_idx == last_r);

    // Reload is allowed in the same cycle the final byte leaves, so words stream without bubbles.
    assign in_ready  = !stall && (!valid_r || (out_ready && at_last));
    assign out_valid = valid_r && !stall;
    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;

    always_comb begin
        valid_nxt    = valid_r;
        byte_idx_nxt = byte_idx;
        if (accept) begin
            valid_nxt    = 1'b1;
            byte_idx_nxt = 2'd0;
        end else if (emit) begin
            if (!at_last) begin
                byte_idx_nxt = byte_idx + 2'd1;
            end else begin
                valid_nxt = 1'b0;
            end
        end
    end

    always_comb begin
        out_data = data_r[31:24];
        case (byte_idx)
            2'd0:    out_data = data_r[31:24];
            2'd1:    out_data = data_r[23:16];
            2'd2:    out_data = data_r[15:8];
            default: out_data = data_r[7:0];
        endcase
    end

    assign out_startofpacket = sop_r && (byte_idx == 2'd0);
    assign out_endofpacket   = eop_r && at_last;

    // byte_idx is mirrored into the external state RAM on every change; a stall never changes it.
    assign state_address   = 1'b0;
    assign state_writedata = byte_idx_nxt;
    assign state_write     = (byte_idx_nxt != byte_idx);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_r   <= 32'd0;
            sop_r    <= 1'b0;
            eop_r    <= 1'b0;
            last_r   <= 2'd0;
            valid_r  <= 1'b0;
            byte_idx <= 2'd0;
        end else begin
            valid_r  <= valid_nxt;
            byte_idx <= byte_idx_nxt;
            if (accept) begin
                data_r <= in_data;
                sop_r  <= in_startofpacket;
                eop_r  <= in_endofpacket;
                last_r <= in_endofpacket ? (2'd3 - in_empty) : 2'd3;
            end
        end
    end

`ifdef ST_WIDTH_ADAPTER_ERROR_EN
    logic error_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            error_r <= 1'b0;
        end else if (accept) begin
            error_r <= in_error;
        end
    end

    assign out_error = error_r && out_valid;
`endif

endmodule

// File: tb/tb_st_width_adapter_32_to_8.sv
// Directed self-checking bench for st_width_adapter_32_to_8.
// Define ST_WIDTH_ADAPTER_ERROR_EN to also exercise the error pass-through.
module tb_st_width_adapter_32_to_8;

    logic        clk;
    logic        reset_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_startofpacket;
    logic        in_endofpacket;
    logic [1:0]  in_empty;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_startofpacket;
    logic        out_endofpacket;
    logic        state_address;
    logic [1:0]  state_writedata;
    logic        state_write;
    logic        state_waitrequest;
`ifdef ST_WIDTH_ADAPTER_ERROR_EN
    logic        in_error;
    logic        out_error;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    st_width_adapter_32_to_8 dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_startofpacket  (in_startofpacket),
        .in_endofpacket    (in_endofpacket),
        .in_empty          (in_empty),
`ifdef ST_WIDTH_ADAPTER_ERROR_EN
        .in_error          (in_error),
        .out_error         (out_error),
`endif
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket),
        .state_address     (state_address),
        .state_writedata   (state_writedata),
        .state_write       (state_write),
        .state_waitrequest (state_waitrequest)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input logic [31:0] d, input logic sop, input logic eop, input logic [1:0] emp);
        in_data          = d;
        in_startofpacket = sop;
        in_endofpacket   = eop;
        in_empty         = emp;
    endtask

    task automatic check_byte(input string tag, input logic [7:0] d, input logic sop, input logic eop);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_data"}, {24'd0, out_data}, {24'd0, d});
        check({tag, "_sop"}, {31'd0, out_startofpacket}, {31'd0, sop});
        check({tag, "_eop"}, {31'd0, out_endofpacket}, {31'd0, eop});
    endtask

    initial begin
        logic [7:0] exp_a [4];
        logic [7:0] exp_b [8];
        logic [1:0] exp_wd [7];

        reset_n           = 1'b0;
        state_waitrequest = 1'b1;
        in_valid          = 1'b0;
        out_ready         = 1'b0;
        set_word(32'd0, 1'b0, 1'b0, 2'd0);
`ifdef ST_WIDTH_ADAPTER_ERROR_EN
        in_error = 1'b0;
`endif
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_out_sop", {31'd0, out_startofpacket}, 32'd0);
        check("rst_out_eop", {31'd0, out_endofpacket}, 32'd0);
        check("rst_state_write", {31'd0, state_write}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_state_addr", {31'd0, state_address}, 32'd0);
        reset_n = 1'b1;
        tick();
        state_waitrequest = 1'b0;

        // full word, single packet
        exp_a = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        set_word(32'hA1B2_C3D4, 1'b1, 1'b1, 2'd0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("t1_idle_in_ready", {31'd0, in_ready}, 32'd1);
        check("t1_idle_out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        in_valid = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check_byte($sformatf("t1_b%0d", i), exp_a[i], i == 0, i == 3);
            check($sformatf("t1_b%0d_in_ready", i), {31'd0, in_ready}, {31'd0, i == 3});
            tick();
        end
        check("t1_done_valid", {31'd0, out_valid}, 32'd0);

        // back-to-back streaming words
        exp_b  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        exp_wd = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        set_word(32'h1122_3344, 1'b1, 1'b0, 2'd0);
        in_valid = 1'b1;
        #1;
        check("t2_w1_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        set_word(32'h5566_7788, 1'b0, 1'b1, 2'd0);
        #1;
        for (int i = 0; i < 8; i++) begin
            check_byte($sformatf("t2_b%0d", i), exp_b[i], i == 0, i == 7);
            check($sformatf("t2_b%0d_in_ready", i), {31'd0, in_ready}, {31'd0, (i == 3) || (i == 7)});
            check($sformatf("t2_b%0d_state_write", i), {31'd0, state_write}, {31'd0, i < 7});
            if (i < 7) begin
                check($sformatf("t2_b%0d_state_wd", i), {30'd0, state_writedata}, {30'd0, exp_wd[i]});
            end
            tick();
            if (i == 3) begin
                in_valid = 1'b0;
                #1;
            end
        end
        check("t2_done_valid", {31'd0, out_valid}, 32'd0);

        // short eop word (empty=2) followed by a single-byte packet (empty=3)
        set_word(32'hDEAD_BEEF, 1'b1, 1'b1, 2'd2);
        in_valid = 1'b1;
        #1;
        tick();
        set_word(32'h0102_0304, 1'b1, 1'b1, 2'd3);
        #1;
        check_byte("t3_de", 8'hDE, 1'b1, 1'b0);
        check("t3_de_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check_byte("t3_ad", 8'hAD, 1'b0, 1'b1);
        check("t3_ad_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        check_byte("t3_single", 8'h01, 1'b1, 1'b1);
        check("t3_single_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("t3_done_valid", {31'd0, out_valid}, 32'd0);

        // out_ready 1,0,0,1 then a one-cycle waitrequest stall
        set_word(32'hCAFE_F00D, 1'b1, 1'b1, 2'd0);
        in_valid = 1'b1;
        #1;
        tick();
        in_valid = 1'b0;
        #1;
        check_byte("t4_ca", 8'hCA, 1'b1, 1'b0);
        tick();
        out_ready = 1'b0;
        #1;
        check_byte("t4_fe_stall1", 8'hFE, 1'b0, 1'b0);
        check("t4_stall1_state_write", {31'd0, state_write}, 32'd0);
        check("t4_stall1_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check_byte("t4_fe_stall2", 8'hFE, 1'b0, 1'b0);
        out_ready = 1'b1;
        #1;
        check("t4_fe_go_state_write", {31'd0, state_write}, 32'd1);
        check("t4_fe_go_state_wd", {30'd0, state_writedata}, 32'd2);
        tick();
        state_waitrequest = 1'b1;
        #1;
        check("t4_wait_out_valid", {31'd0, out_valid}, 32'd0);
        check("t4_wait_in_ready", {31'd0, in_ready}, 32'd0);
        check("t4_wait_state_write", {31'd0, state_write}, 32'd0);
        tick();
        state_waitrequest = 1'b0;
        #1;
        check_byte("t4_f0", 8'hF0, 1'b0, 1'b0);
        tick();
        check_byte("t4_0d", 8'h0D, 1'b0, 1'b1);
        tick();
        check("t4_done_valid", {31'd0, out_valid}, 32'd0);

        // reset mid-word, waitrequest held for two cycles after release
        set_word(32'h1357_9BDF, 1'b1, 1'b1, 2'd0);
        in_valid = 1'b1;
        #1;
        tick();
        in_valid = 1'b0;
        #1;
        check_byte("t5_13", 8'h13, 1'b1, 1'b0);
        tick();
        check_byte("t5_57", 8'h57, 1'b0, 1'b0);
        tick();
        reset_n           = 1'b0;
        state_waitrequest = 1'b1;
        #1;
        check("t5_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("t5_rst_out_data", {24'd0, out_data}, 32'd0);
        check("t5_rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("t5_rst_state_write", {31'd0, state_write}, 32'd0);
        tick();
        reset_n = 1'b1;
        set_word(32'h2468_ACE0, 1'b1, 1'b1, 2'd0);
        in_valid = 1'b1;
        #1;
        check("t5_wait1_out_valid", {31'd0, out_valid}, 32'd0);
        check("t5_wait1_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check("t5_wait2_out_valid", {31'd0, out_valid}, 32'd0);
        check("t5_wait2_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        state_waitrequest = 1'b0;
        #1;
        check("t5_go_in_ready", {31'd0, in_ready}, 32'd1);
        check("t5_go_out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        in_valid = 1'b0;
        #1;
        check_byte("t5_first", 8'h24, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        check("t5_done_valid", {31'd0, out_valid}, 32'd0);

`ifdef ST_WIDTH_ADAPTER_ERROR_EN
        // error flag follows its own word
        set_word(32'h0A0B_0C0D, 1'b1, 1'b0, 2'd0);
        in_error = 1'b1;
        in_valid = 1'b1;
        #1;
        tick();
        set_word(32'h1A1B_1C1D, 1'b0, 1'b1, 2'd0);
        in_error = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t6_b%0d_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("t6_b%0d_error", i), {31'd0, out_error}, {31'd0, i < 4});
            tick();
            if (i == 3) begin
                in_valid = 1'b0;
                #1;
            end
        end
        check("t6_done_error", {31'd0, out_error}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/st_width_adapter_32_to_8.md
ST_WIDTH_ADAPTER_32_TO_8 -- requirements
Module: st_width_adapter_32_to_8

Interface
REQ-001 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-002 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port in_data  input  32  input word; symbol 0 in bits 31:24, symbol 3 in bits 7:0.
REQ-004 SHALL have ports in_valid / in_ready  input / output  1 / 1  input beat handshake.
REQ-005 SHALL have ports in_startofpacket / in_endofpacket  input  1 / 1  packet delimiters.
REQ-006 SHALL have port in_empty  input  2  unused trailing symbols, valid only with in_endofpacket.
REQ-007 SHALL have ports out_data / out_valid / out_ready  output / output / input  8 / 1 / 1  output byte handshake.
REQ-008 SHALL have ports out_startofpacket / out_endofpacket  output  1 / 1  byte-level delimiters.
REQ-009 SHALL have ports state_address / state_writedata / state_write  output  1 / 2 / 1  write port into the 1-deep, 2-bit state RAM.
REQ-010 SHALL have port state_waitrequest  input  1  state RAM busy (clearing after reset).

Function
REQ-011 SHALL hold one word in registers data_r[31:0], sop_r, eop_r, last_r[1:0], valid_r, byte_idx[1:0].
REQ-012 SHALL set last_r = 3 - in_empty when in_endofpacket=1, else 3; in_empty ignored when in_endofpacket=0.
REQ-013 SHALL drive in_ready = !state_waitrequest && (!valid_r || (out_ready && byte_idx==last_r)), combinationally (zero-bubble reload).
REQ-014 SHALL on in_valid&&in_ready load data_r/sop_r/eop_r/last_r, set valid_r=1, byte_idx=0; first byte visible on out_data the next cycle (1-cycle latency).
REQ-015 SHALL drive out_valid = valid_r && !state_waitrequest; out_data = symbol byte_idx of data_r.
REQ-016 SHALL drive out_startofpacket = sop_r && byte_idx==0; out_endofpacket = eop_r && byte_idx==last_r.
REQ-017 SHALL on out_valid&&out_ready with byte_idx<last_r increment byte_idx; with byte_idx==last_r clear valid_r unless a new word is loaded same cycle.
REQ-018 SHALL hold out_data and delimiters stable while out_valid=1 and out_ready=0.
REQ-019 SHALL sustain 4 output bytes per full input word with no idle cycles between words when both sides stream.
REQ-020 SHALL pulse state_write=1 for one cycle whenever byte_idx changes value, with state_writedata = new byte_idx and state_address = 0; state_write=0 otherwise.
REQ-021 SHALL treat state_waitrequest=1 as stall: no beats accepted or emitted, no register changes, state_write=0.
REQ-022 SHALL emit a single byte (sop and eop both set) for an input beat with sop, eop and in_empty=3.

Reset
REQ-023 SHALL on reset_n=0 clear valid_r, sop_r, eop_r, byte_idx, last_r, data_r to 0 asynchronously; out_valid, out_data, out_startofpacket, out_endofpacket, state_write = 0.
REQ-024 SHALL discard any partially emitted word on reset mid-packet; no byte of it appears after reset release.

Configuration
REQ-025 SHALL with macro ST_WIDTH_ADAPTER_ERROR_EN defined add in_error (input, 1) and out_error (output, 1); in_error captured with the word, out_error = captured value on every byte of that word while out_valid=1, reset value 0.
REQ-026 SHALL without ST_WIDTH_ADAPTER_ERROR_EN omit in_error/out_error ports and their register entirely.

Verification
REQ-027 Full word 0xA1B2C3D4, sop=1 eop=1 empty=0, out_ready=1 -> bytes A1,B2,C3,D4 on 4 consecutive cycles, sop on A1, eop on D4, in_ready high only on D4 cycle.
REQ-028 Back-to-back words 0x11223344, 0x55667788 streaming -> 8 consecutive output bytes, no gap, state_writedata sequence 1,2,3,0,1,2,3.
REQ-029 eop word 0xDEADBEEF, empty=2 -> bytes DE, AD only; eop on AD; next word accepted on AD cycle.
REQ-030 out_ready toggling 1,0,0,1 mid-word -> byte held stable during stall, no byte lost or duplicated, byte_idx unchanged.
REQ-031 reset_n=0 after second byte of a word, state_waitrequest held 1 for 2 cycles after release -> out_valid=0, in_ready=0 throughout, first byte after release is byte 0 of the next accepted word.
REQ-032 (ERROR_EN) word with in_error=1 then word with in_error=0 -> out_error=1 on all 4 bytes of first, 0 on all of second.
